mdu_seq: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits beside the combinational ALU in the EX stage.
- Adds widths, configurable latencies, multiply-accumulate and exception cancel, none of which the single-cycle ALU supports.
- EX-stage stall logic stalls any MD-class instruction while Start or Busy is asserted.

---
 rtl/mdu_seq.sv | 212 +++++++++++++++++++++
 tb/tb_mdu_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit with HI/LO registers.
// Sits beside the EX-stage ALU; Busy stalls MD-class instructions.
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDOp,
    input  logic [WIDTH-1:0] In0,
    input  logic [WIDTH-1:0] In1,
    input  logic             Cancel,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int W2   = 2 * WIDTH;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_mul;
    logic             w_is_div;
    logic [W2-1:0]    w_sa;
    logic [W2-1:0]    w_sb;
    logic [W2-1:0]    w_ua;
    logic [W2-1:0]    w_ub;
    logic [W2-1:0]    w_prod_s;
    logic [W2-1:0]    w_prod_u;
    logic [W2-1:0]    w_acc;
    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_b_nz;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_den_u;
    logic [WIDTH-1:0] w_den_s;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;
    logic [WIDTH-1:0] w_sq;
    logic [WIDTH-1:0] w_sr;
    logic [WIDTH-1:0] w_q_s;
    logic [WIDTH-1:0] w_r_s;
    logic [W2-1:0]    w_res;
    logic             w_wr;

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Classify the op presented at issue.
    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        case (MDOp)
            OP_MULT, OP_MULTU, OP_MADD,
            OP_MADDU, OP_MSUB, OP_MSUBU: w_is_mul = 1'b1;
            OP_DIV, OP_DIVU:             w_is_div = 1'b1;
            default: ;
        endcase
    end

    // Products and accumulator in 2*WIDTH bits (sign-extend then wrap).
    assign w_sa     = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_sb     = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_ua     = {{WIDTH{1'b0}}, r_a};
    assign w_ub     = {{WIDTH{1'b0}}, r_b};
    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = w_ua * w_ub;
    assign w_acc    = {r_hi, r_lo};

    // Division on magnitudes; zero divisor is steered to 1 and the write suppressed.
    assign w_neg_a = r_a[WIDTH-1];
    assign w_neg_b = r_b[WIDTH-1];
    assign w_b_nz  = |r_b;
    assign w_abs_a = w_neg_a ? -r_a : r_a;
    assign w_abs_b = w_neg_b ? -r_b : r_b;
    assign w_den_u = w_b_nz ? r_b : {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_den_s = w_b_nz ? w_abs_b : {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_uq    = r_a / w_den_u;
    assign w_ur    = r_a % w_den_u;
    assign w_sq    = w_abs_a / w_den_s;
    assign w_sr    = w_abs_a % w_den_s;
    assign w_q_s   = (w_neg_a ^ w_neg_b) ? -w_sq : w_sq;
    assign w_r_s   = w_neg_a ? -w_sr : w_sr;

    // Select the {HI,LO} result for the latched op.
    always_comb begin
        w_res = w_acc;
        w_wr  = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res = w_prod_s;
                w_wr  = 1'b1;
            end
            OP_MULTU: begin
                w_res = w_prod_u;
                w_wr  = 1'b1;
            end
            OP_MADD: begin
                w_res = w_acc + w_prod_s;
                w_wr  = 1'b1;
            end
            OP_MADDU: begin
                w_res = w_acc + w_prod_u;
                w_wr  = 1'b1;
            end
            OP_MSUB: begin
                w_res = w_acc - w_prod_s;
                w_wr  = 1'b1;
            end
            OP_MSUBU: begin
                w_res = w_acc - w_prod_u;
                w_wr  = 1'b1;
            end
            OP_DIV: begin
                w_res = {w_r_s, w_q_s};
                w_wr  = w_b_nz;
            end
            OP_DIVU: begin
                w_res = {w_ur, w_uq};
                w_wr  = w_b_nz;
            end
            default: ;
        endcase
    end

    // Issue/run FSM with HI/LO write on the last run edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_op    <= OP_NONE;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start && !Cancel) begin
                        if (MDOp == OP_MTHI) begin
                            r_hi <= In0;
                        end else if (MDOp == OP_MTLO) begin
                            r_lo <= In0;
                        end else if (w_is_mul || w_is_div) begin
                            r_op    <= MDOp;
                            r_a     <= In0;
                            r_b     <= In1;
                            r_cnt   <= w_is_div ? CW'(DIV_CYCLES)
                                                : CW'(MULT_CYCLES);
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (Cancel) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_op    <= OP_NONE;
                        r_state <= S_IDLE;
                    end else if (r_cnt == CW'(1)) begin
                        if (w_wr) begin
                            {r_hi, r_lo} <= w_res;
                        end
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_op    <= OP_NONE;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed + random checks of mdu_seq at WIDTH=32/5/10
// and WIDTH=16/1/1 against an arithmetic reference model.
module tb_mdu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        st0, c0, bz0;
    logic [3:0]  op0;
    logic [31:0] a0, b0, hi0, lo0;
    logic        st1, c1, bz1;
    logic [3:0]  op1;
    logic [15:0] a1, b1, hi1, lo1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mhi [2];
    logic [31:0] mlo [2];
    int          wd  [2];
    int          mc  [2];
    int          dc  [2];

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(st0), .MDOp(op0),
        .In0(a0), .In1(b0), .Cancel(c0), .Busy(bz0), .HI(hi0), .LO(lo0)
    );

    mdu_seq #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
        .clk(clk), .reset(reset), .Start(st1), .MDOp(op1),
        .In0(a1), .In1(b1), .Cancel(c1), .Busy(bz1), .HI(hi1), .LO(lo1)
    );

    // Reference: plain integer arithmetic at width w.
    function automatic void ref_op(
        input int w, input logic [3:0] op,
        input logic [31:0] a, b, hi_i, lo_i,
        output logic [31:0] hi_o, lo_o);
        logic [63:0] m1, m2, ua, ub, acc, full, t;
        longint sa, sb, q, r;
        bit mul;
        m1 = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
        m2 = (w == 32) ? '1 : 64'hFFFF_FFFF;
        ua = {32'b0, a} & m1;
        ub = {32'b0, b} & m1;
        if (w == 32) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'($signed(a[15:0]));
            sb = longint'($signed(b[15:0]));
        end
        acc  = (({32'b0, hi_i} & m1) << w) | ({32'b0, lo_i} & m1);
        full = '0;
        mul  = 1'b0;
        hi_o = hi_i;
        lo_o = lo_i;
        case (op)
            4'd1:  begin full = sa * sb;       mul = 1'b1; end
            4'd2:  begin full = ua * ub;       mul = 1'b1; end
            4'd7:  begin full = acc + sa * sb; mul = 1'b1; end
            4'd8:  begin full = acc + ua * ub; mul = 1'b1; end
            4'd9:  begin full = acc - sa * sb; mul = 1'b1; end
            4'd10: begin full = acc - ua * ub; mul = 1'b1; end
            4'd3: if (sb != 0) begin
                q = sa / sb;
                r = sa % sb;
                t = q & m1; lo_o = t[31:0];
                t = r & m1; hi_o = t[31:0];
            end
            4'd4: if (ub != 0) begin
                t = ua / ub; lo_o = t[31:0];
                t = ua % ub; hi_o = t[31:0];
            end
            4'd5: begin t = {32'b0, a} & m1; hi_o = t[31:0]; end
            4'd6: begin t = {32'b0, a} & m1; lo_o = t[31:0]; end
            default: ;
        endcase
        if (mul) begin
            full = full & m2;
            t = (full >> w) & m1; hi_o = t[31:0];
            t = full & m1;        lo_o = t[31:0];
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bz_of(input bit d);
        return d ? {31'b0, bz1} : {31'b0, bz0};
    endfunction
    function automatic logic [31:0] hi_of(input bit d);
        return d ? {16'b0, hi1} : hi0;
    endfunction
    function automatic logic [31:0] lo_of(input bit d);
        return d ? {16'b0, lo1} : lo0;
    endfunction

    task automatic drive(input bit d, input logic st, input logic [3:0] op,
                         input logic [31:0] a, b, input logic c);
        if (d) begin
            st1 = st; op1 = op; a1 = a[15:0]; b1 = b[15:0]; c1 = c;
        end else begin
            st0 = st; op0 = op; a0 = a; b0 = b; c0 = c;
        end
    endtask

    // Present one Start for a cycle and advance the model.
    task automatic issue(input bit d, input logic [3:0] op,
                         input logic [31:0] a, b);
        logic [31:0] nh, nl;
        @(negedge clk);
        drive(d, 1'b1, op, a, b, 1'b0);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        ref_op(wd[d], op, a, b, mhi[d], mlo[d], nh, nl);
        mhi[d] = nh;
        mlo[d] = nl;
    endtask

    function automatic int lat_of(input bit d, input logic [3:0] op);
        if (op == 4'd3 || op == 4'd4) return dc[d];
        if (op == 4'd1 || op == 4'd2 || (op >= 4'd7 && op <= 4'd10))
            return mc[d];
        return 0;
    endfunction

    // Issue, check Busy for the whole latency, then check HI/LO.
    task automatic run(input bit d, input logic [3:0] op,
                       input logic [31:0] a, b, input string tag);
        int l;
        l = lat_of(d, op);
        issue(d, op, a, b);
        for (int i = 0; i < l; i++) begin
            chk({tag, "/busy"}, bz_of(d), 32'd1);
            @(posedge clk);
            #1;
        end
        chk({tag, "/idle"}, bz_of(d), 32'd0);
        chk({tag, "/hi"}, hi_of(d), mhi[d]);
        chk({tag, "/lo"}, lo_of(d), mlo[d]);
    endtask

    logic [3:0] ops [10];
    logic [3:0] rop;
    logic [31:0] ra, rb, oh, ol, nh, nl;
    bit rd;

    initial begin
        wd[0] = 32; mc[0] = 5; dc[0] = 10;
        wd[1] = 16; mc[1] = 1; dc[1] = 1;
        for (int i = 0; i < 2; i++) begin
            mhi[i] = '0;
            mlo[i] = '0;
        end
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        #3;
        chk("rst/busy", bz_of(1'b0), 32'd0);
        chk("rst/hi", hi_of(1'b0), 32'd0);
        chk("rst/lo", lo_of(1'b0), 32'd0);
        chk("rst16/busy", bz_of(1'b1), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run(1'b0, 4'd5, 32'h1234_5678, 32'd0, "mthi");
        chk("mthi/tp", hi0, 32'h1234_5678);

        run(1'b0, 4'd1, 32'hFFFF_FFFF, 32'd2, "mult");
        chk("mult/tp_hi", hi0, 32'hFFFF_FFFF);
        chk("mult/tp_lo", lo0, 32'hFFFF_FFFE);
        run(1'b0, 4'd2, 32'hFFFF_FFFF, 32'd2, "multu");
        chk("multu/tp_hi", hi0, 32'h0000_0001);
        chk("multu/tp_lo", lo0, 32'hFFFF_FFFE);

        run(1'b0, 4'd3, -32'sd7, 32'd2, "div");
        chk("div/tp_lo", lo0, 32'hFFFF_FFFD);
        chk("div/tp_hi", hi0, 32'hFFFF_FFFF);

        run(1'b0, 4'd5, 32'd5, 32'd0, "mthi5");
        run(1'b0, 4'd6, 32'd6, 32'd0, "mtlo6");
        run(1'b0, 4'd4, 32'd123, 32'd0, "divu0");
        chk("divu0/tp_hi", hi0, 32'd5);
        chk("divu0/tp_lo", lo0, 32'd6);

        run(1'b0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        chk("divovf/tp_lo", lo0, 32'h8000_0000);
        chk("divovf/tp_hi", hi0, 32'd0);

        run(1'b0, 4'd13, 32'hDEAD_BEEF, 32'd3, "badop");
        run(1'b0, 4'd0, 32'hDEAD_BEEF, 32'd3, "noneop");

        // mthi while busy must be dropped.
        issue(1'b0, 4'd1, 32'd7, 32'd3);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd5, 32'hDEAD_0000, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("busyst/busy", bz_of(1'b0), 32'd1);
        @(posedge clk);
        #1;
        chk("busyst/idle", bz_of(1'b0), 32'd0);
        chk("busyst/hi", hi0, 32'd0);
        chk("busyst/lo", lo0, 32'd21);

        // Cancel at run edge 3 of a div.
        oh = mhi[0];
        ol = mlo[0];
        issue(1'b0, 4'd3, 32'd100, 32'd7);
        mhi[0] = oh;
        mlo[0] = ol;
        repeat (2) @(posedge clk);
        @(negedge clk);
        c0 = 1'b1;
        @(posedge clk);
        #1;
        c0 = 1'b0;
        chk("cancel3/busy", bz_of(1'b0), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("cancel3/hi", hi0, oh);
        chk("cancel3/lo", lo0, ol);

        // Cancel on the final run edge.
        issue(1'b0, 4'd2, 32'd9, 32'd9);
        mhi[0] = oh;
        mlo[0] = ol;
        repeat (4) @(posedge clk);
        #1;
        chk("cancelN/busy", bz_of(1'b0), 32'd1);
        @(negedge clk);
        c0 = 1'b1;
        @(posedge clk);
        #1;
        c0 = 1'b0;
        chk("cancelN/idle", bz_of(1'b0), 32'd0);
        chk("cancelN/hi", hi0, oh);
        chk("cancelN/lo", lo0, ol);

        // Cancel in idle kills a concurrent Start.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd5, 32'hABCD_0000, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("cancelidle/hi", hi0, oh);

        run(1'b0, 4'd5, 32'd0, 32'd0, "mthi0");
        run(1'b0, 4'd6, 32'hFFFF_FFFF, 32'd0, "mtloF");
        run(1'b0, 4'd7, 32'd1, 32'd1, "madd");
        chk("madd/tp_hi", hi0, 32'd1);
        chk("madd/tp_lo", lo0, 32'd0);
        run(1'b0, 4'd10, 32'd2, 32'd1, "msubu");
        chk("msubu/tp_hi", hi0, 32'd0);
        chk("msubu/tp_lo", lo0, 32'hFFFF_FFFE);

        run(1'b1, 4'd1, 32'hFFFF, 32'd2, "m16");
        chk("m16/tp_hi", {16'b0, hi1}, 32'hFFFF);
        chk("m16/tp_lo", {16'b0, lo1}, 32'hFFFE);
        run(1'b1, 4'd5, 32'hFFFF, 32'd0, "mthi16");
        run(1'b1, 4'd6, 32'hFFFF, 32'd0, "mtlo16");
        run(1'b1, 4'd8, 32'd1, 32'd1, "maddu16");
        chk("maddu16/tp_hi", {16'b0, hi1}, 32'd0);
        chk("maddu16/tp_lo", {16'b0, lo1}, 32'd0);
        run(1'b1, 4'd3, 32'h8000, 32'hFFFF, "divovf16");

        for (int i = 0; i < 40; i++) begin
            rd  = bit'(i & 1);
            rop = ops[$urandom_range(0, 9)];
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                ra = rd ? 32'h8000 : 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            run(rd, rop, ra, rb, "rand");
        end

        // Async reset between edges mid-division.
        run(1'b0, 4'd5, 32'h5A5A_5A5A, 32'd0, "pre_hi");
        run(1'b0, 4'd6, 32'hA5A5_A5A5, 32'd0, "pre_lo");
        issue(1'b0, 4'd3, 32'd1000, 32'd7);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst/busy", bz_of(1'b0), 32'd0);
        chk("arst/hi", hi0, 32'd0);
        chk("arst/lo", lo0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mhi[i] = '0;
            mlo[i] = '0;
        end
        repeat (12) @(posedge clk);
        #1;
        chk("arst/post_busy", bz_of(1'b0), 32'd0);
        chk("arst/post_hi", hi0, mhi[0]);
        chk("arst/post_lo", lo0, mlo[0]);
        chk("arst16/hi", hi_of(1'b1), mhi[1]);

        nh = '0;
        nl = '0;
        if (nh !== nl) $display("unexpected");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
